// File: rtl/debug_event_pkg.sv
// Shared constants and types for the debug event FIFO.
//   TS_WIDTH / EVENT_WIDTH : default timestamp width and captured event width
//   debug_event_t          : one queued event {timestamp, switches/buttons}
//   ADR_POP / ADR_STATUS   : Wishbone read selects
//   resp_state_t           : Wishbone response FSM states
package debug_event_pkg;

  localparam int TS_WIDTH    = 24;
  localparam int EVENT_WIDTH = 8;

  typedef struct packed {
    logic [TS_WIDTH-1:0]    ts;
    logic [EVENT_WIDTH-1:0] data;
  } debug_event_t;

  localparam logic ADR_POP    = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_ACK  = 2'd1,
    RESP_ERR  = 2'd2
  } resp_state_t;

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle.
//   peripheral modport: clk_i, rst_i, cyc_i, stb_i, we_i, adr_i, dat_i in;
//                       dat_o, ack_o, err_o, rty_o, stall_o out.
interface wb_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  clk_i;
  logic                  rst_i;
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic                  adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;
  logic                  rty_o;
  logic                  stall_o;

  modport peripheral (
    input  clk_i, rst_i, cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o, rty_o, stall_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write one entry (ignored when full)
//   pop             : remove head entry into pop_data (ignored when empty)
//   pop_data        : last popped entry, held until the next pop
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] pop_data_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign pop_data  = pop_data_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers (wrap naturally at the power-of-two depth), count and read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      pop_data_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r   <= rd_ptr_r + AW'(1);
        pop_data_r <= mem_r[rd_ptr_r];
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/debug_event_fifo.sv
// Wishbone peripheral that timestamps debounced switch/button writes and
// queues them for a host to pop.
//   wb (peripheral) : write = push event dat_i[7:0]; read adr 0 = pop event,
//                     read adr 1 = status {hwm, full, empty, count};
//                     err_o on pop from empty, stall_o on write while full.
//   leds            : last accepted write value
module debug_event_fifo #(
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 24,
  parameter int DATA_WIDTH = 32
) (
  wb_if.peripheral   wb,
  output logic [7:0] leds
);

  import debug_event_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = TS_WIDTH + EVENT_WIDTH;

  resp_state_t           state_r;
  resp_state_t           state_nx_s;
  logic [TS_WIDTH-1:0]   ts_r;
  logic [7:0]            leds_r;
  logic [CW-1:0]         hwm_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  dat_sel_r;

  logic                  full_s;
  logic                  empty_s;
  logic [CW-1:0]         count_s;
  logic [CW-1:0]         count_inc_s;
  logic [EW-1:0]         fifo_rd_s;
  logic [DATA_WIDTH-1:0] rd_ext_s;
  logic [DATA_WIDTH-1:0] status_word_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  err_s;
  logic                  status_s;
  logic                  unused_s;

  // Upper write-data bits carry nothing for this peripheral.
  assign unused_s = ^wb.dat_i[DATA_WIDTH-1:EVENT_WIDTH];

  assign wb.stall_o  = wb.we_i & full_s;
  assign wb.rty_o    = 1'b0;
  assign accept_s    = wb.cyc_i & wb.stb_i & ~wb.stall_o;
  assign push_s      = accept_s & wb.we_i;
  assign pop_s       = accept_s & ~wb.we_i & (wb.adr_i == ADR_POP) & ~empty_s;
  assign err_s       = accept_s & ~wb.we_i & (wb.adr_i == ADR_POP) & empty_s;
  assign status_s    = accept_s & ~wb.we_i & (wb.adr_i == ADR_STATUS);
  assign count_inc_s = count_s + CW'(1);
  assign leds        = leds_r;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (wb.clk_i),
    .rst       (wb.rst_i),
    .push      (push_s),
    .push_data ({ts_r, wb.dat_i[EVENT_WIDTH-1:0]}),
    .pop       (pop_s),
    .pop_data  (fifo_rd_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Zero-extended popped event and the status word layout.
  always_comb begin
    rd_ext_s                          = '0;
    rd_ext_s[EW-1:0]                  = fifo_rd_s;
    status_word_s                     = '0;
    status_word_s[CW-1:0]             = count_s;
    status_word_s[CW]                 = empty_s;
    status_word_s[CW+1]               = full_s;
    status_word_s[2*CW+1:CW+2]        = hwm_r;
  end

  // Popped data lives in the FIFO read register, so dat_o selects between it
  // and the locally held status/error value; both hold between reads.
  assign wb.dat_o = dat_sel_r ? rd_ext_s : dat_r;

  // A reset arriving in the response cycle cancels the pending completion.
  assign wb.ack_o = (state_r == RESP_ACK) && !wb.rst_i;
  assign wb.err_o = (state_r == RESP_ERR) && !wb.rst_i;

  // Response FSM next state: every acceptance answers in the following cycle.
  always_comb begin
    state_nx_s = RESP_IDLE;
    if (err_s) begin
      state_nx_s = RESP_ERR;
    end else if (accept_s) begin
      state_nx_s = RESP_ACK;
    end else begin
      state_nx_s = RESP_IDLE;
    end
  end

  // Response FSM state register.
  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      state_r <= RESP_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Free-running timestamp, wraps modulo 2^TS_WIDTH.
  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_WIDTH'(1);
    end
  end

  // LED mirror and sticky high-water mark (status read rebases it to count).
  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      leds_r <= '0;
      hwm_r  <= '0;
    end else if (push_s) begin
      leds_r <= wb.dat_i[7:0];
      if (count_inc_s > hwm_r) begin
        hwm_r <= count_inc_s;
      end
    end else if (status_s) begin
      hwm_r <= count_s;
    end
  end

  // Read data source and the value returned by status/error reads.
  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      dat_r     <= '0;
      dat_sel_r <= 1'b0;
    end else if (pop_s) begin
      dat_sel_r <= 1'b1;
    end else if (err_s) begin
      dat_r     <= '0;
      dat_sel_r <= 1'b0;
    end else if (status_s) begin
      dat_r     <= status_word_s;
      dat_sel_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_event_fifo.sv
module tb_debug_event_fifo;
  import debug_event_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  wb_if #(.DATA_WIDTH(DW)) bus();
  logic [7:0] leds;

  debug_event_fifo #(.DEPTH(DEPTH), .TS_WIDTH(24), .DATA_WIDTH(DW)) dut (
    .wb   (bus),
    .leds (leds)
  );

  typedef struct {
    int          due;
    bit          is_err;
    logic [31:0] dat;
    logic [7:0]  leds;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ev_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc_cnt  = 0;
  logic [23:0] model_ts = 24'd0;
  int          m_hwm    = 0;
  logic [7:0]  m_leds   = 8'd0;
  logic [31:0] m_dat    = 32'd0;

  initial bus.clk_i = 1'b0;
  always #5 bus.clk_i = ~bus.clk_i;

  // cycle index and the timestamp expected from the counting rule
  always @(posedge bus.clk_i) begin
    cyc_cnt  <= cyc_cnt + 1;
    model_ts <= bus.rst_i ? 24'd0 : model_ts + 24'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] status_word();
    int sz = ev_q.size();
    return 32'(m_hwm * 32 + (sz == DEPTH ? 16 : 0) + (sz == 0 ? 8 : 0) + sz);
  endfunction

  // reference behaviour for one accepted request
  task automatic model_accept(input bit we, input bit adr, input logic [7:0] d);
    exp_t e;
    debug_event_t ev;
    e.due    = cyc_cnt + 1;
    e.is_err = 1'b0;
    if (we) begin
      ev.ts   = model_ts;
      ev.data = d;
      ev_q.push_back({8'd0, ev});
      m_leds = d;
      if (ev_q.size() > m_hwm) m_hwm = ev_q.size();
    end else if (adr == ADR_POP) begin
      if (ev_q.size() == 0) begin
        e.is_err = 1'b1;
        m_dat    = 32'd0;
      end else begin
        m_dat = ev_q.pop_front();
      end
    end else begin
      m_dat = status_word();
      m_hwm = ev_q.size();
    end
    e.dat  = m_dat;
    e.leds = m_leds;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    ev_q.delete();
    m_hwm  = 0;
    m_leds = 8'd0;
    m_dat  = 32'd0;
  endtask

  task automatic do_req(input bit we, input bit adr, input logic [7:0] d, output int waits);
    bit done = 1'b0;
    waits = 0;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.dat_i = {24'($urandom), d};
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge bus.clk_i);
      if (!bus.stall_o) begin
        model_accept(we, adr, d);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge bus.clk_i);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=stalled required=accepted within 40 cycles");
    end
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    bus.rst_i = 1'b1;
    repeat (n) @(posedge bus.clk_i);
    #1;
    bus.rst_i = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge bus.clk_i);
      #1;
    end
  endtask

  // monitor: compares every response against the scoreboard
  always @(negedge bus.clk_i) begin
    exp_t e;
    if (bus.rst_i === 1'b1) begin
      if (exp_q.size() > 0 || bus.ack_o || bus.err_o)
        check("reset_cancels_response", {30'd0, bus.ack_o, bus.err_o}, 32'd0);
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
      e = exp_q.pop_front();
      check("resp_ack_err", {30'd0, bus.ack_o, bus.err_o}, e.is_err ? 32'd1 : 32'd2);
      check("resp_dat_o", bus.dat_o, e.dat);
      check("resp_leds", {24'd0, leds}, {24'd0, e.leds});
    end else if (bus.ack_o || bus.err_o) begin
      check("unexpected_response", {30'd0, bus.ack_o, bus.err_o}, 32'd0);
    end
  end

  int w;
  int r;

  initial begin
    bus.rst_i = 1'b1;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = 1'b0;
    bus.dat_i = 32'd0;
    do_reset(3);

    // reset state
    @(negedge bus.clk_i);
    check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
    check("rst_err", {31'd0, bus.err_o}, 32'd0);
    check("rst_dat_o", bus.dat_o, 32'd0);
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_rty", {31'd0, bus.rty_o}, 32'd0);
    @(posedge bus.clk_i);
    #1;

    // write 0x25 at timestamp 10, pop it, read status
    for (int g = 0; g < 100 && model_ts != 24'd10; g++) idle(1);
    do_req(1'b1, 1'b0, 8'h25, w);
    do_req(1'b0, ADR_POP, 8'h00, w);
    do_req(1'b0, ADR_STATUS, 8'h00, w);

    // fill, stall on the fifth write, release with one pop
    for (int i = 1; i <= 4; i++) do_req(1'b1, 1'b0, 8'(i), w);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.dat_i = 32'h05;
    repeat (2) begin
      @(negedge bus.clk_i);
      check("stall_when_full", {31'd0, bus.stall_o}, 32'd1);
      @(posedge bus.clk_i);
      #1;
    end
    bus.we_i = 1'b0; bus.adr_i = ADR_POP;
    @(negedge bus.clk_i);
    check("read_never_stalls", {31'd0, bus.stall_o}, 32'd0);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(posedge bus.clk_i);
    #1;
    do_req(1'b0, ADR_POP, 8'h00, w);
    do_req(1'b1, 1'b0, 8'h05, w);
    check("fifth_write_no_wait", 32'(w), 32'd0);
    for (int i = 0; i < 4; i++) do_req(1'b0, ADR_POP, 8'h00, w);

    // pop on empty, then status
    do_req(1'b0, ADR_POP, 8'h00, w);
    do_req(1'b0, ADR_STATUS, 8'h00, w);

    // back-to-back pipelined writes, then drain
    do_req(1'b1, 1'b0, 8'hA1, w);
    do_req(1'b1, 1'b0, 8'hA2, w);
    do_req(1'b1, 1'b0, 8'hA3, w);
    for (int i = 0; i < 3; i++) do_req(1'b0, ADR_POP, 8'h00, w);

    // high-water mark behaviour
    do_req(1'b0, ADR_STATUS, 8'h00, w);
    for (int i = 0; i < 3; i++) do_req(1'b1, 1'b0, 8'(8'h30 + i), w);
    do_req(1'b0, ADR_POP, 8'h00, w);
    do_req(1'b0, ADR_STATUS, 8'h00, w);
    do_req(1'b0, ADR_STATUS, 8'h00, w);

    // reset in the response cycle of a write
    do_req(1'b1, 1'b0, 8'h5A, w);
    do_reset(1);
    @(negedge bus.clk_i);
    check("post_rst_leds", {24'd0, leds}, 32'd0);
    check("post_rst_dat_o", bus.dat_o, 32'd0);
    @(posedge bus.clk_i);
    #1;
    do_reset(1);
    do_req(1'b0, ADR_STATUS, 8'h00, w);
    do_req(1'b1, 1'b0, 8'h77, w);
    do_req(1'b0, ADR_POP, 8'h00, w);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        bus.cyc_i = 1'($urandom);
        bus.stb_i = 1'b0;
        idle($urandom_range(1, 3));
        bus.cyc_i = 1'b0;
      end else if (r < 6 && ev_q.size() < DEPTH) begin
        do_req(1'b1, 1'b0, 8'($urandom), w);
      end else if (r < 9 || ev_q.size() == DEPTH) begin
        do_req(1'b0, ADR_POP, 8'h00, w);
      end else begin
        do_req(1'b0, ADR_STATUS, 8'h00, w);
      end
    end

    idle(3);
    check("all_responses_seen", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
